// File: rtl/spc700_addsub_seq.sv
// spc700_addsub_seq: byte-serial SPC700 add/subtract unit (ADC/SBC/ADDW/SUBW/CMPW) with NZVHC flags
module spc700_addsub_seq #(
  parameter int NBYTES = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic                  START,
  input  logic [1:0]            MODE,
  input  logic [8*NBYTES-1:0]   A,
  input  logic [8*NBYTES-1:0]   B,
  input  logic                  CI,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [8*NBYTES-1:0]   S,
  output logic                  CO,
  output logic                  VO,
  output logic                  HO,
  output logic                  ZO,
  output logic                  NO
);
  localparam int W = 8*NBYTES;
  localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam logic [0:0] IDLE = 1'b0, RUN = 1'b1;
  logic [0:0] state;
  logic [W-1:0] a_r, b_r, s_nx;
  logic sub_r, carry, last;
  logic [IW-1:0] idx;
  logic [7:0] ab, bx, sb;
  logic [4:0] lo, hi;
  always_comb begin
    ab = a_r[8*idx +: 8];
    bx = sub_r ? ~b_r[8*idx +: 8] : b_r[8*idx +: 8];
    lo = {1'b0, ab[3:0]} + {1'b0, bx[3:0]} + {4'b0, carry};
    hi = {1'b0, ab[7:4]} + {1'b0, bx[7:4]} + {4'b0, lo[4]};
    sb = {hi[3:0], lo[3:0]};
    s_nx = S;
    s_nx[8*idx +: 8] = sb;
    last = idx == IW'(NBYTES-1);
  end
  assign BUSY = state == RUN;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      DONE  <= 1'b0;
      S     <= '0;
      CO    <= 1'b0;
      VO    <= 1'b0;
      HO    <= 1'b0;
      ZO    <= 1'b0;
      NO    <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      sub_r <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
    end else if (EN) begin
      if (state == IDLE) begin
        DONE <= 1'b0;
        if (START) begin
          a_r   <= A;
          b_r   <= B;
          sub_r <= MODE[0];
          carry <= MODE[1] ? MODE[0] : CI;
          idx   <= '0;
          state <= RUN;
        end
      end else begin
        S     <= s_nx;
        carry <= hi[4];
        idx   <= idx + 1'b1;
        // flags come from the top byte, except Z which spans the whole word
        if (last) begin
          HO    <= lo[4];
          CO    <= hi[4];
          VO    <= ~(ab[7] ^ bx[7]) & (ab[7] ^ sb[7]);
          NO    <= sb[7];
          ZO    <= s_nx == '0;
          DONE  <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_spc700_addsub_seq.sv
// tb_spc700_addsub_seq: vector table + scoreboard bench for the byte-serial add/subtract unit
module tb_spc700_addsub_seq;
  typedef struct {
    logic [1:0]  mode;
    logic [15:0] a, b;
    logic        ci;
    logic [15:0] s;
    logic [4:0]  f;
  } vec_t;
  typedef struct {
    logic [15:0] s;
    logic [4:0]  f;
  } exp_t;

  logic clk = 0, rst_n = 0, en = 1, start = 0, ci = 0;
  logic [1:0] mode = 0;
  logic [15:0] a = 0, b = 0, s;
  logic busy, done, co, vo, ho, zo, no;
  logic start1 = 0, ci1 = 0;
  logic [1:0] mode1 = 0;
  logic [7:0] a1 = 0, b1 = 0, s1;
  logic busy1, done1, co1, vo1, ho1, zo1, no1;
  int n_vec = 0, n_err = 0, lat = 0;
  exp_t q[$];
  vec_t tbl[10];

  always #5 clk = ~clk;

  spc700_addsub_seq #(.NBYTES(2)) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .START(start), .MODE(mode), .A(a), .B(b), .CI(ci),
    .BUSY(busy), .DONE(done), .S(s), .CO(co), .VO(vo), .HO(ho), .ZO(zo), .NO(no)
  );
  spc700_addsub_seq #(.NBYTES(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .START(start1), .MODE(mode1), .A(a1), .B(b1), .CI(ci1),
    .BUSY(busy1), .DONE(done1), .S(s1), .CO(co1), .VO(vo1), .HO(ho1), .ZO(zo1), .NO(no1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // whole-word reference: H is the carry into bit 12, recovered as a^b^sum
  function automatic exp_t model(input logic [1:0] m, input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [15:0] yx;
    logic [16:0] sum;
    exp_t e;
    yx = m[0] ? ~y : y;
    sum = {1'b0, x} + {1'b0, yx} + {16'b0, m[1] ? m[0] : c};
    e.s = sum[15:0];
    e.f = {sum[16], ~(x[15] ^ yx[15]) & (x[15] ^ sum[15]), x[12] ^ yx[12] ^ sum[12], sum[15:0] == 16'h0, sum[15]};
    return e;
  endfunction

  task automatic start_op(input logic [1:0] m, input logic [15:0] x, input logic [15:0] y, input logic c, input exp_t e);
    mode = m; a = x; b = y; ci = c; start = 1;
    q.push_back(e);
    @(negedge clk);
    start = 0;
    lat = 0;
    chk("busy_run", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int exp_lat);
    exp_t e;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_at_done", 32'(busy), 32'd0);
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: got DONE expected no pending result");
    end else begin
      e = q.pop_front();
      chk("result", 32'(s), 32'(e.s));
      chk("flags_cvhzn", 32'({co, vo, ho, zo, no}), 32'(e.f));
    end
  endtask

  initial begin
    exp_t e;
    logic [1:0] m;
    logic [15:0] x, y;
    logic c;
    tbl[0] = '{2'b10, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 5'b00100};
    tbl[1] = '{2'b10, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 5'b01101};
    tbl[2] = '{2'b11, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 5'b00001};
    tbl[3] = '{2'b11, 16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 5'b10110};
    tbl[4] = '{2'b00, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 5'b10110};
    tbl[5] = '{2'b10, 16'h0001, 16'h0001, 1'b1, 16'h0002, 5'b00000};
    tbl[6] = '{2'b11, 16'h0003, 16'h0001, 1'b0, 16'h0002, 5'b10100};
    tbl[7] = '{2'b01, 16'h1000, 16'h0001, 1'b0, 16'h0FFE, 5'b10000};
    tbl[8] = '{2'b00, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 5'b00000};
    tbl[9] = '{2'b00, 16'h0001, 16'h0001, 1'b0, 16'h0002, 5'b00000};
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_flags", 32'({co, vo, ho, zo, no}), 32'd0);
    rst_n = 1;
    @(negedge clk);
    // single-byte unit: one enabled edge of latency
    for (int i = 0; i < 2; i++) begin
      mode1 = i == 0 ? 2'b01 : 2'b00;
      a1 = i == 0 ? 8'h80 : 8'h3C;
      b1 = i == 0 ? 8'h01 : 8'hC4;
      ci1 = i == 0;
      start1 = 1;
      @(negedge clk);
      start1 = 0;
      chk("b1_busy", 32'(busy1), 32'd1);
      @(negedge clk);
      chk("b1_done", 32'(done1), 32'd1);
      chk("b1_s", 32'(s1), i == 0 ? 32'h7F : 32'h00);
      chk("b1_flags", 32'({co1, vo1, ho1, zo1, no1}), i == 0 ? 32'b11000 : 32'b10110);
    end
    // table vectors, issued back to back on each DONE
    for (int i = 0; i < 10; i++) begin
      e.s = tbl[i].s;
      e.f = tbl[i].f;
      start_op(tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].ci, e);
      wait_done(2);
    end
    for (int i = 0; i < 12; i++) begin
      m = 2'($urandom_range(0, 3));
      x = 16'($urandom);
      y = 16'($urandom);
      c = 1'($urandom_range(0, 1));
      start_op(m, x, y, c, model(m, x, y, c));
      wait_done(2);
    end
    // EN stall mid-run: low byte written, high byte still from the previous 0002
    @(negedge clk);
    start_op(2'b10, 16'h0001, 16'h0001, 1'b0, model(2'b10, 16'h0001, 16'h0001, 1'b0));
    wait_done(2);
    e.s = 16'h2201; e.f = 5'b00100;
    start_op(2'b10, 16'h1234, 16'h0FCD, 1'b0, e);
    @(negedge clk);
    lat++;
    en = 0;
    chk("stall_low_byte", 32'(s), 32'h0001);
    repeat (3) begin
      @(negedge clk);
      lat++;
      chk("stall_s", 32'(s), 32'h0001);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_done", 32'(done), 32'd0);
    end
    en = 1;
    wait_done(5);
    en = 0;
    repeat (2) begin
      @(negedge clk);
      chk("done_hold", 32'(done), 32'd1);
    end
    en = 1;
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
    // START pulsed while busy is dropped
    e.s = 16'h8000; e.f = 5'b01101;
    start_op(2'b10, 16'h7FFF, 16'h0001, 1'b0, e);
    mode = 2'b00; a = 16'hFFFF; b = 16'hFFFF; ci = 1; start = 1;
    @(negedge clk);
    lat++;
    start = 0;
    wait_done(2);
    @(negedge clk);
    chk("no_queue_busy", 32'(busy), 32'd0);
    chk("no_queue_done", 32'(done), 32'd0);
    chk("no_queue_s", 32'(s), 32'h8000);
    // reset mid-run with EN low still aborts
    start_op(2'b11, 16'h0000, 16'h0001, 1'b0, model(2'b11, 16'h0000, 16'h0001, 1'b0));
    rst_n = 0;
    en = 0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_s", 32'(s), 32'd0);
    chk("abort_flags", 32'({co, vo, ho, zo, no}), 32'd0);
    q.delete();
    rst_n = 1;
    en = 1;
    @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);
    e.s = 16'h0002; e.f = 5'b00000;
    start_op(2'b10, 16'h0001, 16'h0001, 1'b0, e);
    wait_done(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
